// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo widths, tag map and station-entry types.
// No timing of its own; the snoop helper is pure combinational logic.
package tomasulo_pkg;
    localparam int DATA_W          = 8;
    localparam int TAG_W           = 3;
    localparam int ADD_TAG_BASE    = 1;
    localparam int MUL_TAG_BASE    = 4;
    localparam int MUL_NUM_ENTRIES = 3;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef enum logic [1:0] {
        RS_FREE,
        RS_WAIT,
        RS_READY,
        RS_EXEC
    } rs_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } opnd_t;

    // Resolve one operand against a CDB broadcast; tag 0 never matches.
    function automatic opnd_t snoop_opnd(
        input opnd_t             cur,
        input logic              cdb_valid,
        input logic [TAG_W-1:0]  cdb_tag,
        input logic [DATA_W-1:0] cdb_data
    );
        opnd_t res;
        res = cur;
        if (cdb_valid && (cur.tag != TAG_NONE) && (cur.tag == cdb_tag)) begin
            res.tag = TAG_NONE;
            res.val = cdb_data;
        end
        return res;
    endfunction
endpackage

// File: rtl/mul_reservation_station_if.sv
// Issue, CDB snoop and multiplier-side signals of the MUL reservation station.
// master = instruction queue / CDB side, slave = the station.
interface mul_reservation_station_if;
    import tomasulo_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_tag;
    logic [TAG_W-1:0]  issue_qj;
    logic [DATA_W-1:0] issue_vj;
    logic [TAG_W-1:0]  issue_qk;
    logic [DATA_W-1:0] issue_vk;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              mul_start;
    logic              mul_valid;
    logic [TAG_W-1:0]  mul_tag;
    logic [DATA_W-1:0] mul_op_a;
    logic [DATA_W-1:0] mul_op_b;

    modport master (
        output issue_valid, issue_qj, issue_vj, issue_qk, issue_vk,
        output cdb_valid, cdb_tag, cdb_data,
        input  issue_ready, issue_tag,
        input  mul_start, mul_valid, mul_tag, mul_op_a, mul_op_b
    );

    modport slave (
        input  issue_valid, issue_qj, issue_vj, issue_qk, issue_vk,
        input  cdb_valid, cdb_tag, cdb_data,
        output issue_ready, issue_tag,
        output mul_start, mul_valid, mul_tag, mul_op_a, mul_op_b
    );
endinterface

// File: rtl/mul_reservation_station_rs_entry.sv
// One station slot: FREE -> WAIT/READY -> EXEC -> FREE, snooping the CDB for its operands.
// Issue write, snoop capture and state moves all land on the next clock edge.
module rs_entry
    import tomasulo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_wr,
    input  opnd_t             issue_j,
    input  opnd_t             issue_k,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              dispatch,
    input  logic              free_exec,
    output rs_state_e         state,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk
);
    rs_state_e state_q, state_d;
    opnd_t     opj_q, opj_d;
    opnd_t     opk_q, opk_d;
    opnd_t     new_j, new_k;
    opnd_t     snp_j, snp_k;

    always_comb begin
        state_d = state_q;
        opj_d   = opj_q;
        opk_d   = opk_q;
        // Bypass catches a producer broadcasting in the very cycle of issue.
        new_j   = snoop_opnd(issue_j, cdb_valid, cdb_tag, cdb_data);
        new_k   = snoop_opnd(issue_k, cdb_valid, cdb_tag, cdb_data);
        snp_j   = snoop_opnd(opj_q, cdb_valid, cdb_tag, cdb_data);
        snp_k   = snoop_opnd(opk_q, cdb_valid, cdb_tag, cdb_data);
        case (state_q)
            RS_FREE: begin
                if (issue_wr) begin
                    opj_d   = new_j;
                    opk_d   = new_k;
                    state_d = ((new_j.tag == TAG_NONE) && (new_k.tag == TAG_NONE))
                              ? RS_READY : RS_WAIT;
                end
            end
            RS_WAIT: begin
                opj_d = snp_j;
                opk_d = snp_k;
                if ((snp_j.tag == TAG_NONE) && (snp_k.tag == TAG_NONE)) begin
                    state_d = RS_READY;
                end
            end
            RS_READY: begin
                if (dispatch) begin
                    state_d = RS_EXEC;
                end
            end
            RS_EXEC: begin
                if (free_exec) begin
                    state_d = RS_FREE;
                end
            end
            default: state_d = RS_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RS_FREE;
            opj_q   <= '0;
            opk_q   <= '0;
        end else begin
            state_q <= state_d;
            opj_q   <= opj_d;
            opk_q   <= opk_d;
        end
    end

    assign state = state_q;
    assign vj    = opj_q.val;
    assign vk    = opk_q.val;
endmodule

// File: rtl/mul_reservation_station.sv
// MUL reservation station: renames issues to tags, snoops the CDB, feeds a non-pipelined multiplier.
// Dispatch one edge after an entry turns READY; issue_ready drops only when every entry is taken.
module mul_reservation_station
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENTRIES = MUL_NUM_ENTRIES,
    parameter int TAG_BASE    = MUL_TAG_BASE
) (
    input  logic                     clk,
    input  logic                     rst,
    mul_reservation_station_if.slave rs_if
);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    rs_state_e         ent_state [NUM_ENTRIES];
    logic [DATA_W-1:0] ent_vj    [NUM_ENTRIES];
    logic [DATA_W-1:0] ent_vk    [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] free_vec, ready_vec;
    logic [NUM_ENTRIES-1:0] issue_wr_vec, dispatch_vec, free_exec_vec;
    logic [IDX_W-1:0]       free_idx, ready_idx;
    logic                   issue_fire, dispatch_fire, complete_fire;
    opnd_t                  issue_j, issue_k;

    logic              mul_start_q, mul_start_d;
    logic              mul_valid_q, mul_valid_d;
    logic [TAG_W-1:0]  mul_tag_q, mul_tag_d;
    logic [DATA_W-1:0] mul_op_a_q, mul_op_a_d;
    logic [DATA_W-1:0] mul_op_b_q, mul_op_b_d;
    logic [IDX_W-1:0]  exec_idx_q, exec_idx_d;

    // Lowest-index priority: scanning downward leaves the smallest match.
    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        free_idx  = '0;
        ready_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            free_vec[i]  = (ent_state[i] == RS_FREE);
            ready_vec[i] = (ent_state[i] == RS_READY);
            if (ent_state[i] == RS_FREE) begin
                free_idx = IDX_W'(i);
            end
            if (ent_state[i] == RS_READY) begin
                ready_idx = IDX_W'(i);
            end
        end
    end

    assign issue_j = {rs_if.issue_qj, rs_if.issue_vj};
    assign issue_k = {rs_if.issue_qk, rs_if.issue_vk};

    assign issue_fire    = rs_if.issue_valid && (|free_vec);
    assign dispatch_fire = !mul_valid_q && (|ready_vec);
    assign complete_fire = mul_valid_q && rs_if.cdb_valid && (rs_if.cdb_tag == mul_tag_q);

    assign issue_wr_vec  = issue_fire    ? (NUM_ENTRIES'(1) << free_idx)   : '0;
    assign dispatch_vec  = dispatch_fire ? (NUM_ENTRIES'(1) << ready_idx)  : '0;
    assign free_exec_vec = complete_fire ? (NUM_ENTRIES'(1) << exec_idx_q) : '0;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
        rs_entry u_ent (
            .clk       (clk),
            .rst       (rst),
            .issue_wr  (issue_wr_vec[g]),
            .issue_j   (issue_j),
            .issue_k   (issue_k),
            .cdb_valid (rs_if.cdb_valid),
            .cdb_tag   (rs_if.cdb_tag),
            .cdb_data  (rs_if.cdb_data),
            .dispatch  (dispatch_vec[g]),
            .free_exec (free_exec_vec[g]),
            .state     (ent_state[g]),
            .vj        (ent_vj[g]),
            .vk        (ent_vk[g])
        );
    end

    // Dispatch needs mul_valid_q low, so it never coincides with completion.
    always_comb begin
        mul_start_d = dispatch_fire;
        mul_valid_d = mul_valid_q;
        mul_tag_d   = mul_tag_q;
        mul_op_a_d  = mul_op_a_q;
        mul_op_b_d  = mul_op_b_q;
        exec_idx_d  = exec_idx_q;
        if (dispatch_fire) begin
            mul_valid_d = 1'b1;
            mul_tag_d   = TAG_W'(TAG_BASE) + TAG_W'(ready_idx);
            mul_op_a_d  = ent_vj[ready_idx];
            mul_op_b_d  = ent_vk[ready_idx];
            exec_idx_d  = ready_idx;
        end else if (complete_fire) begin
            mul_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_start_q <= 1'b0;
            mul_valid_q <= 1'b0;
            mul_tag_q   <= '0;
            mul_op_a_q  <= '0;
            mul_op_b_q  <= '0;
            exec_idx_q  <= '0;
        end else begin
            mul_start_q <= mul_start_d;
            mul_valid_q <= mul_valid_d;
            mul_tag_q   <= mul_tag_d;
            mul_op_a_q  <= mul_op_a_d;
            mul_op_b_q  <= mul_op_b_d;
            exec_idx_q  <= exec_idx_d;
        end
    end

    assign rs_if.issue_ready = |free_vec;
    assign rs_if.issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    assign rs_if.mul_start   = mul_start_q;
    assign rs_if.mul_valid   = mul_valid_q;
    assign rs_if.mul_tag     = mul_tag_q;
    assign rs_if.mul_op_a    = mul_op_a_q;
    assign rs_if.mul_op_b    = mul_op_b_q;
endmodule
